// File: rtl/prog_sender_if.sv
// Handshake bundle between prog_sender, its program memory and the UART transmitter.
// The master side is the sender; the slave side is memory plus uart_tx (or a bench).
interface prog_sender_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   words_sent;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (
    input  start, mem_rdata, tx_busy,
    output busy, done, overflow, words_sent, mem_addr, tx_data, tx_start
  );

  modport slave (
    output start, mem_rdata, tx_busy,
    input  busy, done, overflow, words_sent, mem_addr, tx_data, tx_start
  );
endinterface

// File: rtl/prog_sender.sv
// Streams a program image to uart_tx in boot-loader format: sync byte, then 32-bit
// words MSB byte first, ending after a zero word (appended if memory has none).
module prog_sender #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic         clk,
  input  logic         rstn,
  prog_sender_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_RD, S_LATCH, S_SEND, S_ACK, S_DRAIN, S_TERM, S_FIN
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic [31:0]       r_word,       w_word_nxt;
  logic [1:0]        r_idx,        w_idx_nxt;
  logic              r_sync,       w_sync_nxt;
  logic [ADDR_W:0]   r_words_sent, w_words_sent_nxt;
  logic              r_overflow,   w_overflow_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [7:0]        r_tx_data,    w_tx_data_nxt;

  logic [7:0]        w_byte;
  logic              w_strobe;
  logic              w_addr_last;

  always_comb begin
    case (r_idx)
      2'd0:    w_byte = r_word[31:24];
      2'd1:    w_byte = r_word[23:16];
      2'd2:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end

  assign w_strobe    = (r_state == S_SEND) && !bus.tx_busy;
  assign w_addr_last = (r_mem_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_word       <= 32'h0;
      r_idx        <= 2'd0;
      r_sync       <= 1'b0;
      r_words_sent <= '0;
      r_overflow   <= 1'b0;
      r_mem_addr   <= '0;
      r_tx_data    <= 8'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
      r_sync       <= w_sync_nxt;
      r_words_sent <= w_words_sent_nxt;
      r_overflow   <= w_overflow_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_word_nxt       = r_word;
    w_idx_nxt        = r_idx;
    w_sync_nxt       = r_sync;
    w_words_sent_nxt = r_words_sent;
    w_overflow_nxt   = r_overflow;
    w_mem_addr_nxt   = r_mem_addr;
    w_tx_data_nxt    = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_words_sent_nxt = '0;
          w_overflow_nxt   = 1'b0;
          w_mem_addr_nxt   = '0;
          w_state_nxt      = S_SYNC;
        end
      end
      // The sync byte rides through SEND as the top byte of a pseudo-word.
      S_SYNC: begin
        w_word_nxt  = {SYNC_BYTE, 24'h0};
        w_idx_nxt   = 2'd0;
        w_sync_nxt  = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_RD:    w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_word_nxt  = bus.mem_rdata;
        w_idx_nxt   = 2'd0;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_data_nxt = w_byte;
          w_state_nxt   = S_ACK;
        end
      end
      S_ACK: begin
        if (bus.tx_busy) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.tx_busy) begin
          if (r_sync) begin
            w_sync_nxt  = 1'b0;
            w_state_nxt = S_RD;
          end else if (r_idx != 2'd3) begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_SEND;
          end else begin
            w_words_sent_nxt = r_words_sent + 1'b1;
            if (r_word == 32'h0) begin
              w_state_nxt = S_FIN;
            end else if (w_addr_last) begin
              w_overflow_nxt = 1'b1;
              w_state_nxt    = S_TERM;
            end else begin
              w_mem_addr_nxt = r_mem_addr + 1'b1;
              w_state_nxt    = S_RD;
            end
          end
        end
      end
      S_TERM: begin
        w_word_nxt  = 32'h0;
        w_idx_nxt   = 2'd0;
        w_state_nxt = S_SEND;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobe and its data are decoded from state so reset kills them without a clock.
  assign bus.tx_start   = w_strobe;
  assign bus.tx_data    = w_strobe ? w_byte : r_tx_data;
  assign bus.busy       = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.done       = (r_state == S_FIN);
  assign bus.overflow   = r_overflow;
  assign bus.words_sent = r_words_sent;
  assign bus.mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_prog_sender.sv
// Randomized bench for prog_sender: memory and uart_tx models, plus a reference
// that derives the expected byte stream straight from the boot-loader format.
module tb_prog_sender;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  prog_sender_if #(.ADDR_W(AW)) bus ();

  prog_sender #(.ADDR_W(AW), .SYNC_BYTE(8'hAA)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.master)
  );

  logic [31:0] mem [DEPTH];
  logic [31:0] m_rdata = 32'h0;
  logic        m_busy = 1'b0;
  int          busy_cnt = 0;
  logic        stall = 1'b0;
  logic        stall_used = 1'b0;
  int          nstrobe = 0;
  int          hold_at = -1;
  logic        strobe_seen = 1'b0;

  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int          viol = 0;
  int          checks = 0;
  int          errors = 0;

  assign bus.mem_rdata = m_rdata;
  assign bus.tx_busy   = m_busy;

  always @(posedge clk) m_rdata <= mem[bus.mem_addr];

  // uart_tx model: busy from the cycle after a strobe for a random length;
  // optionally drops busy for one cycle then re-asserts it for 1000 cycles.
  always @(posedge clk) begin
    if (strobe_seen) begin
      m_busy   <= 1'b1;
      busy_cnt <= $urandom_range(1, 5);
      nstrobe  <= nstrobe + 1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      m_busy   <= 1'b0;
      if (nstrobe == hold_at && !stall_used) begin
        stall      <= 1'b1;
        stall_used <= 1'b1;
      end
    end else if (stall) begin
      stall    <= 1'b0;
      m_busy   <= 1'b1;
      busy_cnt <= 1000;
    end
  end

  always @(negedge clk) begin
    strobe_seen <= bus.tx_start;
    if (bus.tx_start) cap.push_back(bus.tx_data);
    if (bus.tx_start && bus.tx_busy) viol++;
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic build_ref(output int ws, output bit ov);
    bit found = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    ws = 0;
    ov = 1'b0;
    for (int a = 0; a < DEPTH && !found; a++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(mem[a] >> (24 - 8 * k)));
      ws++;
      if (mem[a] == 32'h0) found = 1'b1;
    end
    if (!found) begin
      ov = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
      ws++;
    end
  endtask

  task automatic run_xfer(input bit repulse);
    int ws_e;
    bit ov_e;
    int base;
    int dbase;
    bit seen;
    build_ref(ws_e, ov_e);
    base  = cap.size();
    dbase = done_cnt;
    seen  = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("busy_n1", bus.busy, 1);
    @(negedge clk);
    if (bus.tx_busy == 1'b0) begin
      chk("sync_strobe_n2", bus.tx_start, 1);
      chk("sync_data_n2", bus.tx_data, 8'hAA);
    end
    if (repulse) begin
      repeat (8) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) chk("busy_at_done", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - dbase, 1);
    chk("words_sent", bus.words_sent, ws_e);
    chk("overflow", bus.overflow, ov_e);
    chk("nbytes", cap.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap.size(); i++)
      chk($sformatf("byte%0d", i), cap[base + i], exp_q[i]);
  endtask

  task automatic wait_uart_idle();
    for (int c = 0; c < 2000 && m_busy; c++) @(negedge clk);
    chk("uart_idle", m_busy, 0);
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'h0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_words", bus.words_sent, 0);
    chk("rst_addr", bus.mem_addr, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    mem[0] = 32'h2001_0005; mem[1] = 32'hFC00_0000; mem[2] = 32'h0; mem[3] = 32'h1234_5678;
    run_xfer(1'b0);

    mem[0] = 32'h0; mem[1] = 32'hDEAD_BEEF;
    run_xfer(1'b0);

    for (int a = 0; a < DEPTH; a++) mem[a] = 32'h1111_1111;
    run_xfer(1'b0);

    mem[0] = 32'h2001_0005; mem[1] = 32'hFC00_0000; mem[2] = 32'h0;
    run_xfer(1'b1);

    hold_at = nstrobe + 3;
    run_xfer(1'b0);
    chk("stall_hit", stall_used, 1);

    mem[0] = 32'h0102_0304; mem[1] = 32'h0506_0708; mem[2] = 32'h0;
    base = cap.size();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      if (cap.size() >= base + 7) break;
      @(negedge clk);
    end
    chk("rst_point", cap.size() >= base + 7, 1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_tx_start", bus.tx_start, 0);
    chk("arst_tx_data", bus.tx_data, 0);
    chk("arst_words", bus.words_sent, 0);
    chk("arst_ovf", bus.overflow, 0);
    chk("arst_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_uart_idle();
    run_xfer(1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < DEPTH; a++)
        mem[a] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      run_xfer(1'b0);
    end

    chk("proto_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
